// File: rtl/fmps_test_pkg.sv
// Shared constants, status codes and receive-state encoding for the FMPS test-link checker.
package fmps_test_pkg;

    localparam logic [15:0] HDR_MAGIC        = 16'hB6CF;
    localparam logic [15:0] DATA_MARKER      = 16'hCACA;
    localparam int          FMPS_INDEX_WIDTH = 5;

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_HDR_ERR   = 2'd1;
    localparam logic [1:0] ST_DATA_ERR  = 2'd2;
    localparam logic [1:0] ST_FRAME_ERR = 2'd3;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_HEADER = 2'd1,
        RX_DATA   = 2'd2,
        RX_RESYNC = 2'd3
    } rx_state_e;

endpackage

// File: rtl/fmps_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module fmps_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/read_fmps_test_link.sv
// Checks FMPS test packets (header + data beat) arriving over an Aurora AXI-stream and reports status.
// Optional macro READ_FMPS_TEST_LINK_LATENCY_EN adds the firstHeaderLatency output.
module read_fmps_test_link
    import fmps_test_pkg::*;
#(
    parameter int MAX_FMPSS = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        auroraUserClk,
    input  logic                        auroraUserRst_n,
    input  logic                        auroraFAstrobe,
    input  logic                        auroraChannelUp,
    input  logic [FMPS_INDEX_WIDTH-1:0] baseIndex,
    input  logic [31:0]                 FMPS_TEST_AXI_STREAM_RX_tdata,
    input  logic                        FMPS_TEST_AXI_STREAM_RX_tvalid,
    input  logic                        FMPS_TEST_AXI_STREAM_RX_tlast,
    output logic                        FMPS_TEST_AXI_STREAM_RX_tready,
    output logic                        TESTstatusStrobe,
    output logic [1:0]                  TESTstatusCode,
    output logic [CNT_WIDTH-1:0]        packetCount,
    output logic [CNT_WIDTH-1:0]        errorCount,
`ifdef READ_FMPS_TEST_LINK_LATENCY_EN
    output logic [15:0]                 firstHeaderLatency,
`endif
    output logic [2:0]                  dbgRxState
);

    localparam int IDX_W = FMPS_INDEX_WIDTH;

    rx_state_e        state_q, state_d;
    logic [7:0]       cyc_q, cyc_d;
    logic [IDX_W-1:0] pkt_idx_q, pkt_idx_d;
    logic             strobe_q, strobe_d;
    logic [1:0]       code_q, code_d;

    logic             beat;
    logic [IDX_W-1:0] exp_idx;
    logic             hdr_good;
    logic             data_good;
    logic [31:0]      td;
    logic             tl;

    assign td = FMPS_TEST_AXI_STREAM_RX_tdata;
    assign tl = FMPS_TEST_AXI_STREAM_RX_tlast;

    // Reset must drop tready immediately, so it is folded in combinationally.
    assign FMPS_TEST_AXI_STREAM_RX_tready = auroraUserRst_n & auroraChannelUp & ~auroraFAstrobe;
    assign beat = FMPS_TEST_AXI_STREAM_RX_tvalid & FMPS_TEST_AXI_STREAM_RX_tready;

    assign exp_idx  = baseIndex + pkt_idx_q;
    assign hdr_good = (td[31:16] == HDR_MAGIC) && td[15] && (td[14:10] == exp_idx)
                      && (td[9:0] == 10'd0) && !tl;
    // tlast is checked separately so framing errors take precedence over field errors.
    assign data_good = (td[31:29] == 3'd0) && (td[28:24] == pkt_idx_q)
                       && (td[23:8] == DATA_MARKER) && (td[7:0] == cyc_q);

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        pkt_idx_d = pkt_idx_q;
        strobe_d  = 1'b0;
        code_d    = ST_OK;
        if (auroraFAstrobe) begin
            cyc_d     = cyc_q + 8'd1;
            pkt_idx_d = '0;
            state_d   = RX_HEADER;
        end else if (!auroraChannelUp) begin
            state_d = RX_IDLE;
        end else if (beat) begin
            unique case (state_q)
                RX_IDLE: ;
                RX_HEADER: begin
                    if (hdr_good) begin
                        state_d = RX_DATA;
                    end else if (tl) begin
                        strobe_d = 1'b1;
                        code_d   = ST_FRAME_ERR;
                    end else begin
                        strobe_d = 1'b1;
                        code_d   = ST_HDR_ERR;
                        state_d  = RX_RESYNC;
                    end
                end
                RX_DATA: begin
                    strobe_d = 1'b1;
                    if (!tl) begin
                        code_d  = ST_FRAME_ERR;
                        state_d = RX_RESYNC;
                    end else begin
                        code_d    = data_good ? ST_OK : ST_DATA_ERR;
                        pkt_idx_d = pkt_idx_q + 1'b1;
                        state_d   = RX_HEADER;
                    end
                end
                RX_RESYNC: begin
                    if (tl) begin
                        pkt_idx_d = pkt_idx_q + 1'b1;
                        state_d   = RX_HEADER;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge auroraUserClk or negedge auroraUserRst_n) begin
        if (!auroraUserRst_n) begin
            state_q   <= RX_IDLE;
            cyc_q     <= 8'd0;
            pkt_idx_q <= '0;
            strobe_q  <= 1'b0;
            code_q    <= ST_OK;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            pkt_idx_q <= pkt_idx_d;
            strobe_q  <= strobe_d;
            code_q    <= code_d;
        end
    end

    // Counters advance on the same edge that registers the strobe, so they line up with it.
    fmps_sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
        .clk_i (auroraUserClk),
        .rst_ni(auroraUserRst_n),
        .clr_i (1'b0),
        .inc_i (strobe_d),
        .cnt_o (packetCount)
    );

    fmps_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk_i (auroraUserClk),
        .rst_ni(auroraUserRst_n),
        .clr_i (1'b0),
        .inc_i (strobe_d && (code_d != ST_OK)),
        .cnt_o (errorCount)
    );

`ifdef READ_FMPS_TEST_LINK_LATENCY_EN
    logic lat_active_q, lat_active_d;

    always_comb begin
        lat_active_d = lat_active_q;
        if (auroraFAstrobe) begin
            lat_active_d = 1'b1;
        end else if (beat && (state_q == RX_HEADER) && hdr_good) begin
            lat_active_d = 1'b0;
        end
    end

    always_ff @(posedge auroraUserClk or negedge auroraUserRst_n) begin
        if (!auroraUserRst_n) begin
            lat_active_q <= 1'b0;
        end else begin
            lat_active_q <= lat_active_d;
        end
    end

    fmps_sat_counter #(.WIDTH(16)) u_lat_cnt (
        .clk_i (auroraUserClk),
        .rst_ni(auroraUserRst_n),
        .clr_i (auroraFAstrobe),
        .inc_i (lat_active_q),
        .cnt_o (firstHeaderLatency)
    );
`endif

    assign TESTstatusStrobe = strobe_q;
    assign TESTstatusCode   = code_q;
    assign dbgRxState       = {1'b0, state_q};

    logic unused_ok;
    assign unused_ok = (MAX_FMPSS > 0);

endmodule

// File: tb/tb_read_fmps_test_link.sv
// Scoreboard bench for read_fmps_test_link: stimulus pushes expected status codes, a monitor pops them.
module tb_read_fmps_test_link;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fa;
    logic        ch_up;
    logic [4:0]  base_idx;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic        st_strobe;
    logic [1:0]  st_code;
    logic [7:0]  pkt_cnt;
    logic [7:0]  err_cnt;
    logic [2:0]  dbg;
`ifdef READ_FMPS_TEST_LINK_LATENCY_EN
    logic [15:0] lat;
`endif

    always #5 clk = ~clk;

    read_fmps_test_link #(.MAX_FMPSS(32), .CNT_WIDTH(8)) dut (
        .auroraUserClk                  (clk),
        .auroraUserRst_n                (rst_n),
        .auroraFAstrobe                 (fa),
        .auroraChannelUp                (ch_up),
        .baseIndex                      (base_idx),
        .FMPS_TEST_AXI_STREAM_RX_tdata  (tdata),
        .FMPS_TEST_AXI_STREAM_RX_tvalid (tvalid),
        .FMPS_TEST_AXI_STREAM_RX_tlast  (tlast),
        .FMPS_TEST_AXI_STREAM_RX_tready (tready),
        .TESTstatusStrobe               (st_strobe),
        .TESTstatusCode                 (st_code),
        .packetCount                    (pkt_cnt),
        .errorCount                     (err_cnt),
`ifdef READ_FMPS_TEST_LINK_LATENCY_EN
        .firstHeaderLatency             (lat),
`endif
        .dbgRxState                     (dbg)
    );

    int tests = 0;
    int fails = 0;
    logic [1:0] expq[$];
    int exp_pkt = 0;
    int exp_err = 0;
    logic [7:0] cyc = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] code);
        expq.push_back(code);
        if (exp_pkt < 255) exp_pkt++;
        if (code != 2'd0 && exp_err < 255) exp_err++;
    endtask

    function automatic logic [31:0] hdr(input logic [4:0] idx);
        return {16'hB6CF, 1'b1, idx, 10'd0};
    endfunction

    function automatic logic [31:0] dat(input logic [4:0] idx, input logic [7:0] c);
        return {3'd0, idx, 16'hCACA, c};
    endfunction

    task automatic beat(input logic [31:0] d, input logic last);
        tdata  = d;
        tlast  = last;
        tvalid = 1'b1;
        @(posedge clk); #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic strobe_fa();
        fa = 1'b1;
        @(posedge clk); #1;
        fa = 1'b0;
        cyc = cyc + 8'd1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string name);
        idle(2);
        check({name, "_pkt"}, {24'd0, pkt_cnt}, exp_pkt);
        check({name, "_err"}, {24'd0, err_cnt}, exp_err);
    endtask

    always @(negedge clk) begin
        if (st_strobe) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got code %0d, expected no strobe at %0t", st_code, $time);
            end else begin
                check("strobe_code", {30'd0, st_code}, {30'd0, expq.pop_front()});
            end
        end
    end

    initial begin
        rst_n = 1'b0; fa = 1'b0; ch_up = 1'b1; base_idx = 5'd3;
        tdata = 32'd0; tvalid = 1'b0; tlast = 1'b0;
        idle(3);
        check("rst_tready", {31'd0, tready}, 0);
        check("rst_state", {29'd0, dbg}, 0);
        check("rst_strobe", {30'd0, st_strobe, st_code[0]}, 0);
        check("rst_cnt", {16'd0, pkt_cnt, err_cnt}, 0);
        @(negedge clk); rst_n = 1'b1;
        idle(2);
        check("tready_up", {31'd0, tready}, 1);

        // single good packet, baseIndex 3
        strobe_fa();
        beat(32'hB6CF8C00, 1'b0);
        push(2'd0);
        beat(32'h00CACA01, 1'b1);
`ifdef READ_FMPS_TEST_LINK_LATENCY_EN
        check("latency", {16'd0, lat}, 1);
`endif
        check_counts("single");

        // 32 pairs with header index wrapping past 31, then pktIdx back at 0
        strobe_fa();
        for (int i = 0; i < 32; i++) begin
            beat(hdr(5'(3 + i)), 1'b0);
            push(2'd0);
            beat(dat(5'(i), cyc), 1'b1);
        end
        beat(hdr(5'd3), 1'b0);
        push(2'd0);
        beat(dat(5'd0, cyc), 1'b1);
        check_counts("wrap");

        // bad magic -> code 1, data discarded, next pair at pktIdx 1
        strobe_fa();
        beat(32'hB6CE8C00, 1'b0);
        push(2'd1);
        beat(dat(5'd0, cyc), 1'b1);
        beat(hdr(5'd4), 1'b0);
        push(2'd0);
        beat(dat(5'd1, cyc), 1'b1);
        check_counts("hdr_err");

        // wrong cycle byte -> code 2
        strobe_fa();
        beat(hdr(5'd3), 1'b0);
        push(2'd2);
        beat(dat(5'd0, 8'h05), 1'b1);
        check_counts("data_err");

        // framing: tlast on header stays in HEADER; missing tlast on data resyncs
        beat(hdr(5'd4), 1'b1);
        push(2'd3);
        check("hold_header", {29'd0, dbg}, 1);
        beat(hdr(5'd4), 1'b0);
        push(2'd3);
        beat(dat(5'd1, cyc), 1'b0);
        check("resync_state", {29'd0, dbg}, 3);
        beat(32'h12345678, 1'b1);
        beat(hdr(5'd5), 1'b0);
        push(2'd0);
        beat(dat(5'd2, cyc), 1'b1);
        check_counts("frame");

        // strobe coincident with a beat: not accepted, session restarts at 0
        tdata = hdr(5'd3); tvalid = 1'b1; fa = 1'b1;
        @(negedge clk);
        check("fa_tready", {31'd0, tready}, 0);
        @(posedge clk); #1;
        fa = 1'b0; tvalid = 1'b0;
        cyc = cyc + 8'd1;
        beat(hdr(5'd3), 1'b0);
        push(2'd0);
        beat(dat(5'd0, cyc), 1'b1);
        check_counts("fa_beat");

        // channel drop mid-packet abandons it; beats in IDLE are discarded
        beat(hdr(5'd4), 1'b0);
        ch_up = 1'b0;
        idle(2);
        check("down_state", {29'd0, dbg}, 0);
        check("down_tready", {31'd0, tready}, 0);
        ch_up = 1'b1;
        beat(dat(5'd1, cyc), 1'b1);
        beat(hdr(5'd4), 1'b0);
        check_counts("idle");

        // reset pulse mid-DATA
        strobe_fa();
        beat(hdr(5'd3), 1'b0);
        check("pre_rst_state", {29'd0, dbg}, 2);
        @(negedge clk); rst_n = 1'b0; #1;
        check("mid_rst_tready", {31'd0, tready}, 0);
        check("mid_rst_out", {13'd0, dbg, st_strobe, st_code, pkt_cnt, err_cnt}, 0);
        @(negedge clk); rst_n = 1'b1;
        exp_pkt = 0; exp_err = 0; cyc = 8'd0;
        beat(dat(5'd0, 8'd1), 1'b1);
        beat(hdr(5'd3), 1'b1);
        check("post_rst_state", {29'd0, dbg}, 0);
        check_counts("post_rst");

        // saturation of 8-bit counters
        strobe_fa();
        for (int i = 0; i < 260; i++) begin
            beat(hdr(5'd3), 1'b1);
            push(2'd3);
        end
        check_counts("sat");
        check("sat_pkt_255", {24'd0, pkt_cnt}, 255);

        idle(3);
        check("queue_empty", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/read_fmps_test_link.md
READ_FMPS_TEST_LINK -- requirements
Module: read_fmps_test_link

Interface
REQ-001 Parameter MAX_FMPSS, default 32: FMPS index space; FMPS_INDEX_WIDTH = clog2(MAX_FMPSS) = 5.
REQ-002 Parameter CNT_WIDTH, default 16: width of packet and error counters.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 auroraUserClk  in  1  sole clock; all logic rises on it.
REQ-005 auroraUserRst_n  in  1  asynchronous active-low reset.
REQ-006 auroraFAstrobe  in  1  start of readout session, single-cycle pulse.
REQ-007 auroraChannelUp  in  1  link up.
REQ-008 baseIndex  in  5  expected FMPS index of the first packet in a session.
REQ-009 FMPS_TEST_AXI_STREAM_RX_tdata / _tvalid / _tlast  in  32/1/1  AXI-stream sink.
REQ-010 FMPS_TEST_AXI_STREAM_RX_tready  out  1  sink ready.
REQ-011 TESTstatusStrobe  out  1  one-cycle pulse per completed or aborted packet.
REQ-012 TESTstatusCode  out  2  0 OK, 1 header error, 2 data error, 3 framing error; valid only with the strobe.
REQ-013 packetCount, errorCount  out  CNT_WIDTH each  saturating totals.
REQ-014 dbgRxState  out  3  current state encoding.

Function
REQ-015 Beat accepted = tvalid && tready; tready = 1 except in the cycle auroraFAstrobe is high, and 0 while auroraChannelUp = 0.
REQ-016 States: IDLE (0), HEADER (1), DATA (2), RESYNC (3).
REQ-017 auroraFAstrobe, from any state: cycleCnt += 1 (8-bit, wraps), pktIdx <= 0, next state HEADER. It has priority over any beat in that cycle.
REQ-018 In IDLE, accepted beats are discarded: no check, no strobe.
REQ-019 HEADER, beat accepted, header is good when all of the following hold:
- tdata[31:16] = 16'hB6CF
- tdata[15] = 1
- tdata[14:10] = (baseIndex + pktIdx) mod 32
- tdata[9:0] = 0
- tlast = 0
REQ-020 HEADER outcomes:
- Good header: next state DATA.
- tlast = 1: strobe with code 3; stay in HEADER.
- Any other mismatch: strobe with code 1; next state RESYNC.
REQ-021 DATA, beat accepted, data is good when all of the following hold:
- tdata[31:29] = 0
- tdata[28:24] = pktIdx[4:0]
- tdata[23:8] = 16'hCACA
- tdata[7:0] = cycleCnt
- tlast = 1
REQ-022 DATA outcomes:
- Good data: strobe with code 0.
- tlast = 0: strobe with code 3; next state RESYNC.
- Field mismatch: strobe with code 2.
- After code 0 or 2: pktIdx += 1 (wraps at 32), next state HEADER.
REQ-023 RESYNC: discard beats until one with tlast = 1 is accepted, then pktIdx += 1 and next state HEADER.
REQ-024 Strobe latency: TESTstatusStrobe and TESTstatusCode are registered and appear the cycle after the deciding beat.
REQ-025 packetCount increments on every strobe; errorCount increments on every strobe with a nonzero code. Both saturate at all-ones and never wrap.
REQ-026 auroraChannelUp falling: next state IDLE and no strobe; any partial packet is abandoned.

Reset
REQ-027 Reset asserted SHALL immediately force:
- state IDLE, cycleCnt 0, pktIdx 0
- TESTstatusStrobe 0, TESTstatusCode 0
- packetCount 0, errorCount 0
- tready 0
REQ-028 Reset deasserted mid-stream: beats are ignored until the next auroraFAstrobe.

Configuration
REQ-029 Macro READ_FMPS_TEST_LINK_LATENCY_EN, when defined:
- adds output firstHeaderLatency (16 bit).
- Cycles are counted from the auroraFAstrobe cycle (exclusive) to the first accepted good header of the session (inclusive).
- The count saturates; it is cleared by reset and on each strobe.
- The value holds after the first good header.
REQ-030 Without the macro, the port and its counter are absent and all other behaviour is identical.

Structure
REQ-031 Shared package fmps_test_pkg SHALL hold:
- constants: header magic 16'hB6CF, data marker 16'hCACA
- FMPS_INDEX_WIDTH
- status-code constants
- the rx state enum
REQ-032 One sub-module, fmps_sat_counter (parameterised width, increment enable, async active-low reset), SHALL be instantiated for packetCount, errorCount and the latency counter.

Verification
REQ-033 baseIndex = 3, strobe, then header 0xB6CF8C00 + data 0x00CACA01 (tlast on data) -> a single strobe with code 0; packetCount 1, errorCount 0.
REQ-034 Strobe, then 32 good header/data pairs with indices wrapping past 31 -> 32 strobes with code 0, and pktIdx wraps to 0.
REQ-035 Header magic 0xB6CE -> code 1; the data beat is discarded; the next good pair (pktIdx 1) -> code 0.
REQ-036 Data byte[7:0] = 0x05 while cycleCnt = 1 -> code 2; errorCount 1.
REQ-037 Strobe coincident with a valid beat -> tready = 0 that cycle and no strobe; the session restarts with pktIdx 0.
REQ-038 Reset pulse mid-DATA -> all outputs 0 and state IDLE; beats ignored until the next strobe; counters at 255 of 8-bit CNT_WIDTH stay at 255 under further errors.
